fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the team's synchronous FIFO. On a start command it pulls a fixed-length burst of words out of the FIFO and delivers them on a valid/ready output stream. It absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so downstream back-pressure never loses or duplicates a word. It sits between the FIFO's `rd_en`/`data_out`/`empty` port and any stream consumer.

## Interface
- `DATA_WIDTH`, default 8: FIFO word and stream data width.
- `LEN_WIDTH`, default 4: width of `burst_len`; the maximum burst is 2^LEN_WIDTH−1 words.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low; 0 sampled at a rising edge resets the block.
- `start` in 1: one-cycle burst request; sampled only in IDLE.
- `burst_len` in LEN_WIDTH: number of words to read; sampled with `start`. 0 makes `start` a no-op.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when the burst has fully left the block.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_rd_en` out 1: FIFO read strobe; combinational from registered state, `fifo_empty` and `m_ready`.
- `fifo_data` in DATA_WIDTH: FIFO `data_out`; valid the cycle after an accepted `fifo_rd_en`.
- `m_valid` out 1: stream data valid, registered (skid occupancy > 0).
- `m_ready` in 1: consumer accepts the word when `m_valid && m_ready`.
- `m_data` out DATA_WIDTH: head of the skid buffer, registered.

## Operation
- **States:**
  - IDLE → RUN on `start && burst_len != 0`; latch `remaining = burst_len`.
  - RUN → DRAIN when the read that drives `remaining` to 0 is issued.
  - DRAIN → IDLE when skid occupancy is 0 and no read is in flight. `done` pulses in that same transition cycle.
- **Read rule:** `fifo_rd_en = (state==RUN) && !fifo_empty && remaining!=0 && (occ + inflight < 2 || (m_valid && m_ready))`.
  - `inflight` is a 1-bit register: the value of `fifo_rd_en` from the previous cycle.
  - `occ` is the skid occupancy, 0..2.
- **Capture:** when `inflight` is 1, `fifo_data` is written into the skid buffer at the tail. The buffer is FIFO-ordered and never overwrites.
- **Pop:** `m_valid && m_ready` removes the head. A pop and a capture in the same cycle leave `occ` unchanged, and word order is preserved.
- **Decrement:** `remaining` decrements on each issued `fifo_rd_en`. It is never below 0 and never exceeds `burst_len`.
- **Ignored starts:** `start` in RUN or DRAIN is ignored and does not queue.
- **Empty FIFO:** the block stalls in RUN with `fifo_rd_en` held at 0, and resumes the first cycle `fifo_empty` deasserts.
- **Order:** the stream carries exactly `burst_len` words, in FIFO order, with no gaps that the consumer did not cause.

## Timing
- **Reset values:** `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `busy` 0, `done` 0; state IDLE, `occ` 0, `inflight` 0, `remaining` 0.
- **Reset mid-burst:** everything returns to the reset values on the next edge. A word in flight from the FIFO is discarded, because the FIFO pointer has already advanced.
- **Latency:**
  - `start` sampled at edge E0.
  - `busy` and the first possible `fifo_rd_en` in cycle E0+1.
  - First `m_valid` at E0+3 (read issued at k, data on `fifo_data` at k+1, `m_valid` at k+2).
- **Throughput:** 1 word/clk with `m_ready` held high and the FIFO non-empty.
- **Burst timing:** an N-word burst with no stalls shows `done` at E0+N+3, and `busy` falls in that same cycle.
- **Back-pressure:** with `m_ready` low, at most 2 words sit in the skid buffer and `fifo_rd_en` stays 0 until a pop frees a slot. `m_data` and `m_valid` are stable while `m_valid && !m_ready`.

## Configuration
- **Macro:** `FIFO_READER_COUNT_EN`.
- **Defined:** adds output `rd_count` (16 bits), a total of words delivered on the stream since reset.
  - Increments on each `m_valid && m_ready`.
  - Saturates at 16'hFFFF.
  - Cleared only by reset; not cleared by `start`.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Basic burst:** FIFO preloaded with 8'h11, 8'h22, 8'h33, 8'h44; `burst_len`=4, `m_ready`=1 → stream carries 11, 22, 33, 44 on 4 consecutive cycles from E0+3, `done` at E0+7, FIFO left empty.
- **Back-pressure:** same preload, `m_ready` low for cycles E0+2..E0+8 → `fifo_rd_en` issues exactly 2 reads then holds 0, and `m_data`=8'h11 stays stable. After `m_ready` rises, all 4 words arrive in order and none is lost.
- **Underflow stall:** FIFO empty at start with `burst_len`=3, one word written every 4 cycles → `fifo_rd_en` never asserts while `fifo_empty`=1, 3 words are delivered, then a single `done` pulse.
- **Ignored start:** `start` with `burst_len`=0 → remains IDLE, `busy`=0. A second `start` during RUN with `burst_len`=5 → the current burst length is unchanged and no extra reads occur.
- **Reset mid-burst:** `reset`=0 for one edge while `m_valid`=1 and `inflight`=1 → next cycle all outputs are 0 and state is IDLE. A following burst of 2 delivers the next 2 FIFO words.
- **Counter (`FIFO_READER_COUNT_EN` defined):** two bursts of 4 and 3 words → `rd_count`=7. After reset, `rd_count`=0.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the synchronous FIFO.
// On start it reads a burst of burst_len words from the FIFO and presents them
// on a valid/ready stream. A 2-entry skid buffer absorbs the FIFO's one-cycle
// read latency so back-pressure never drops or duplicates a word.
// Optional feature macro: FIFO_READER_COUNT_EN adds the rd_count output.
//
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   start,burst_len - burst request and length (sampled in IDLE only)
//   busy, done      - burst active / one-cycle completion pulse
//   fifo_empty      - FIFO empty flag
//   fifo_rd_en      - FIFO read strobe (combinational)
//   fifo_data       - FIFO read data, valid the cycle after a read
//   m_valid,m_ready - output stream handshake
//   m_data          - output stream data (head of skid buffer)
//   rd_count        - words delivered since reset (FIFO_READER_COUNT_EN only)
module fifo_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_READER_COUNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    localparam int unsigned OCC_WIDTH = 2;
    localparam int unsigned SUM_WIDTH = OCC_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [LEN_WIDTH-1:0]   remaining, remaining_n;
    logic [OCC_WIDTH-1:0]   occ, occ_n;
    logic                   inflight;
    logic [DATA_WIDTH-1:0]  skid1, skid1_n;
    logic [DATA_WIDTH-1:0]  m_data_n;
    logic                   busy_n, done_n, m_valid_n;
    logic                   pop;

    // State and datapath registers; m_data doubles as skid slot 0 (the head).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            occ       <= '0;
            inflight  <= 1'b0;
            skid1     <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            occ       <= occ_n;
            inflight  <= fifo_rd_en;
            skid1     <= skid1_n;
            m_data    <= m_data_n;
            m_valid   <= m_valid_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Read issue, skid buffer update and next-state logic.
    always_comb begin
        pop         = m_valid && m_ready;
        fifo_rd_en  = 1'b0;
        state_n     = state;
        remaining_n = remaining;
        occ_n       = occ;
        skid1_n     = skid1;
        m_data_n    = m_data;
        done_n      = 1'b0;

        // A read may be issued into a full slot only if a pop frees one this cycle.
        fifo_rd_en = (state == RUN) && !fifo_empty && (remaining != '0) &&
                     (((SUM_WIDTH'(occ) + SUM_WIDTH'(inflight)) < SUM_WIDTH'(2)) || pop);

        if (fifo_rd_en) begin
            remaining_n = remaining - LEN_WIDTH'(1);
        end

        case ({inflight, pop})
            2'b10: begin
                if (occ == '0) m_data_n = fifo_data;
                else           skid1_n  = fifo_data;
                occ_n = occ + OCC_WIDTH'(1);
            end
            2'b01: begin
                if (occ == OCC_WIDTH'(2)) m_data_n = skid1;
                occ_n = occ - OCC_WIDTH'(1);
            end
            2'b11: begin
                if (occ == OCC_WIDTH'(2)) begin
                    m_data_n = skid1;
                    skid1_n  = fifo_data;
                end else begin
                    m_data_n = fifo_data;
                end
            end
            default: ;
        endcase

        case (state)
            IDLE: begin
                if (start && (burst_len != '0)) begin
                    state_n     = RUN;
                    remaining_n = burst_len;
                end
            end
            RUN: begin
                if (fifo_rd_en && (remaining == LEN_WIDTH'(1))) state_n = DRAIN;
            end
            DRAIN: begin
                // Leave once the buffer will be empty with nothing in flight,
                // so done and the fall of busy appear together.
                if ((occ_n == '0) && !fifo_rd_en) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n    = (state_n != IDLE);
        m_valid_n = (occ_n != '0);
    end

`ifdef FIFO_READER_COUNT_EN
    // Saturating count of delivered words; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count <= '0;
        end else if (pop && (rd_count != {CNT_WIDTH{1'b1}})) begin
            rd_count <= rd_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader with a behavioural FIFO and stream scoreboard.
module tb_fifo_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          reset, start, fifo_empty, fifo_rd_en, m_valid, m_ready, busy, done;
    logic [LW-1:0] burst_len;
    logic [DW-1:0] fifo_data = '0;
    logic [DW-1:0] m_data;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0]   rd_count;
`endif

    logic [DW-1:0] fmem [0:2047];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    int tests = 0, fails = 0;
    int got_words, rd_cnt, done_cnt, exp_idx, total_words;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    int base;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef FIFO_READER_COUNT_EN
        , .rd_count(rd_count)
`endif
    );

    // Behavioural FIFO: registered data_out one cycle after an accepted read.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fmem[rd_ptr[10:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        fmem[wr_ptr[10:0]] = v;
        wr_ptr++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor: read legality, stall stability, stream order, done pulses.
    task automatic mon();
        @(negedge clk);
        if (fifo_rd_en) begin
            rd_cnt++;
            chk("rd_on_empty", 32'(fifo_empty), 32'd0);
        end
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (reset && m_valid && m_ready) begin
            chk("stream_data", 32'(m_data), 32'(fmem[exp_idx[10:0]]));
            exp_idx++;
            got_words++;
            total_words++;
        end
        if (done) done_cnt++;
        prev_stall = reset && m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    task automatic cyc(input logic rdy);
        tick();
        start   = 1'b0;
        m_ready = rdy;
        mon();
    endtask

    task automatic begin_burst(input int len, input logic rdy);
        rd_cnt = 0; got_words = 0; done_cnt = 0; exp_idx = rd_ptr;
        tick();
        start = 1'b1; burst_len = LW'(len); m_ready = rdy;
        mon();
    endtask

    task automatic finish_burst(input int len, input int mode, input int tmo);
        int c;
        c = 0;
        while (done_cnt == 0 && c < tmo) begin
            tick();
            start   = 1'b0;
            m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mode != 0 && (wr_ptr - rd_ptr) < 4 && $urandom_range(0, 1) == 1)
                push(8'($urandom));
            mon();
            c++;
        end
        repeat (3) cyc(1'b1);
        chk("burst_words", 32'(got_words), 32'(len));
        chk("burst_reads", 32'(rd_cnt), 32'(len));
        chk("burst_done_pulses", 32'(done_cnt), 32'd1);
        chk("burst_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; burst_len = '0; m_ready = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        got_words = 0; rd_cnt = 0; done_cnt = 0; exp_idx = 0; total_words = 0;

        // Reset values
        tick(); mon(); tick(); mon();
        chk_reset_outputs("reset");
`ifdef FIFO_READER_COUNT_EN
        chk("reset_rd_count", 32'(rd_count), 32'd0);
`endif
        tick(); reset = 1'b1; mon();

        // Basic burst: 4 words at full rate, first valid at E0+3, done at E0+7
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        begin_burst(4, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            cyc(1'b1);
            if (c == 1) begin
                chk("basic_busy_e1", 32'(busy), 32'd1);
                chk("basic_rd_e1", 32'(fifo_rd_en), 32'd1);
            end
            if (c == 2) chk("basic_novalid_e2", 32'(m_valid), 32'd0);
            if (c >= 3 && c <= 6) chk("basic_valid", 32'(m_valid), 32'd1);
            if (c == 3) chk("basic_first_word", 32'(m_data), 32'h11);
            if (c == 6) chk("basic_no_early_done", 32'(done), 32'd0);
            if (c == 7) begin
                chk("basic_done_e7", 32'(done), 32'd1);
                chk("basic_busy_low_e7", 32'(busy), 32'd0);
            end
            if (c == 8) chk("basic_done_single", 32'(done), 32'd0);
        end
        chk("basic_words", 32'(got_words), 32'd4);
        chk("basic_reads", 32'(rd_cnt), 32'd4);
        chk("basic_done_count", 32'(done_cnt), 32'd1);
        chk("basic_fifo_empty", 32'(fifo_empty), 32'd1);

        // Back-pressure: m_ready low E0+2..E0+8
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        begin_burst(4, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            cyc((c < 2) ? 1'b1 : 1'b0);
            if (c >= 4) chk("bp_rd_held", 32'(fifo_rd_en), 32'd0);
            if (c >= 3) begin
                chk("bp_valid", 32'(m_valid), 32'd1);
                chk("bp_head", 32'(m_data), 32'h11);
            end
        end
        chk("bp_two_reads", 32'(rd_cnt), 32'd2);
        finish_burst(4, 0, 40);

        // Underflow stall: FIFO empty, one word every 4 cycles
        chk("uf_start_empty", 32'(fifo_empty), 32'd1);
        begin_burst(3, 1'b1);
        for (int c = 1; c <= 30; c++) begin
            tick();
            start = 1'b0; m_ready = 1'b1;
            if (c % 4 == 2 && c < 12) push(8'($urandom));
            mon();
            if (c == 1) chk("uf_busy", 32'(busy), 32'd1);
        end
        chk("uf_words", 32'(got_words), 32'd3);
        chk("uf_reads", 32'(rd_cnt), 32'd3);
        chk("uf_done_count", 32'(done_cnt), 32'd1);

        // Ignored starts: zero length, then a start during RUN
        begin_burst(0, 1'b1);
        cyc(1'b1);
        chk("zero_len_busy1", 32'(busy), 32'd0);
        cyc(1'b1);
        chk("zero_len_busy2", 32'(busy), 32'd0);
        chk("zero_len_reads", 32'(rd_cnt), 32'd0);
        for (int i = 0; i < 5; i++) push(8'($urandom));
        begin_burst(3, 1'b1);
        cyc(1'b1);
        tick(); start = 1'b1; burst_len = LW'(5); m_ready = 1'b1; mon();
        finish_burst(3, 0, 40);
        chk("ign_leftover", 32'(wr_ptr - rd_ptr), 32'd2);

        // Reset mid-burst with m_valid=1 and a read in flight
        for (int i = 0; i < 4; i++) push(8'($urandom));
        base = rd_ptr;
        begin_burst(4, 1'b0);
        cyc(1'b0); cyc(1'b0);
        tick(); m_ready = 1'b0; reset = 1'b0; mon();
        chk("rst_pre_valid", 32'(m_valid), 32'd1);
        chk("rst_pre_reads", 32'(rd_cnt), 32'd2);
        tick(); reset = 1'b1; mon();
        total_words = 0;
        chk_reset_outputs("midrst");
        chk("midrst_fifo_reads", 32'(rd_ptr - base), 32'd2);
`ifdef FIFO_READER_COUNT_EN
        chk("midrst_rd_count", 32'(rd_count), 32'd0);
`endif
        cyc(1'b1);
        chk("midrst_idle", 32'(busy), 32'd0);
        begin_burst(2, 1'b1);
        finish_burst(2, 0, 40);

        // Randomised bursts with random back-pressure and FIFO arrivals
        for (int i = 0; i < 10; i++) begin
            int len;
            len = int'($urandom_range(1, 15));
            begin_burst(len, 1'b1);
            finish_burst(len, 1, 300);
        end

`ifdef FIFO_READER_COUNT_EN
        chk("count_total", 32'(rd_count), 32'(total_words));
`endif
        tick(); reset = 1'b0; mon();
        tick(); reset = 1'b1; mon();
        chk_reset_outputs("final_rst");
`ifdef FIFO_READER_COUNT_EN
        chk("final_rd_count", 32'(rd_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
